// File: rtl/gate_check_ctrl_if.sv
// Bundle between the gate self-test sequencer and its environment.
// Ports: start/op launch a run; dut_a/dut_b/dut_out connect the gate under test;
//        vec_idx/busy/done/pass/err_count/fail_vec report progress and results.
interface gate_check_ctrl_if;
  logic       start;
  logic [2:0] op;
  logic       dut_out;
  logic       dut_a;
  logic       dut_b;
  logic [1:0] vec_idx;
  logic       busy;
  logic       done;
  logic       pass;
  logic [2:0] err_count;
  logic [3:0] fail_vec;

  // master: the sequencer itself
  modport master (
    input  start, op, dut_out,
    output dut_a, dut_b, vec_idx, busy, done, pass, err_count, fail_vec
  );

  // slave: whoever launches runs, hosts the gate and reads results
  modport slave (
    output start, op, dut_out,
    input  dut_a, dut_b, vec_idx, busy, done, pass, err_count, fail_vec
  );
endinterface

// File: rtl/gate_check_ctrl.sv
// Purpose: drives vectors 00,01,11,10 into a two-input gate, checks its output against op's truth table.
// Latency: done pulses 4*HOLD_CYCLES+1 cycles after the start edge (1 cycle for an illegal op).
// Backpressure: none; start is sampled only in IDLE and dropped otherwise (never queued).
// Ports: clk, rst_n (async active-low); bus (master modport) carries start/op, the gate
//        pins dut_a/dut_b/dut_out, and status vec_idx/busy/done/pass/err_count/fail_vec.
module gate_check_ctrl #(
  parameter int HOLD_CYCLES = 10
) (
  input  logic               clk,
  input  logic               rst_n,
  gate_check_ctrl_if.master  bus
);

  typedef enum logic [1:0] {IDLE, DRIVE, REPORT} state_t;

  state_t     state, state_n;
  logic [1:0] idx, idx_n;
  logic [7:0] cnt, cnt_n;
  logic [2:0] op_q, op_n;
  logic [2:0] err, err_n;
  logic [3:0] fail, fail_n;
  logic       pass, pass_n;
  logic       busy, busy_n;
  logic       done, done_n;

  logic       vec_a, vec_b, expect_out;

  // Vector order 00,01,11,10 is a Gray sequence: a = idx[1], b = idx[1]^idx[0].
  assign vec_a = idx[1];
  assign vec_b = idx[1] ^ idx[0];

  always_comb begin
    expect_out = 1'b0;
    case (op_q)
      3'd0:    expect_out =   vec_a & vec_b;
      3'd1:    expect_out =   vec_a | vec_b;
      3'd2:    expect_out = ~(vec_a & vec_b);
      3'd3:    expect_out = ~(vec_a | vec_b);
      3'd4:    expect_out =   vec_a ^ vec_b;
      3'd5:    expect_out = ~(vec_a ^ vec_b);
      default: expect_out = 1'b0;
    endcase
  end

  always_comb begin
    state_n = state;
    idx_n   = idx;
    cnt_n   = cnt;
    op_n    = op_q;
    err_n   = err;
    fail_n  = fail;
    pass_n  = pass;
    busy_n  = busy;
    done_n  = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          op_n   = bus.op;
          idx_n  = 2'd0;
          cnt_n  = 8'd0;
          pass_n = 1'b0;
          if (bus.op <= 3'd5) begin
            err_n   = 3'd0;
            fail_n  = 4'b0000;
            busy_n  = 1'b1;
            state_n = DRIVE;
          end else begin
            // Illegal function: report total failure without driving anything.
            err_n   = 3'd4;
            fail_n  = 4'b1111;
            done_n  = 1'b1;
            state_n = REPORT;
          end
        end
      end
      DRIVE: begin
        if (cnt == 8'(HOLD_CYCLES - 1)) begin
          if (bus.dut_out != expect_out) begin
            fail_n[idx] = 1'b1;
            err_n       = err + 3'd1;
          end
          cnt_n = 8'd0;
          if (idx == 2'd3) begin
            // pass must already reflect the idx3 compare during the done cycle.
            pass_n  = (err_n == 3'd0);
            busy_n  = 1'b0;
            done_n  = 1'b1;
            idx_n   = 2'd0;
            state_n = REPORT;
          end else begin
            idx_n = idx + 2'd1;
          end
        end else begin
          cnt_n = cnt + 8'd1;
        end
      end
      REPORT: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      idx   <= 2'd0;
      cnt   <= 8'd0;
      op_q  <= 3'd0;
      err   <= 3'd0;
      fail  <= 4'b0000;
      pass  <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_n;
      idx   <= idx_n;
      cnt   <= cnt_n;
      op_q  <= op_n;
      err   <= err_n;
      fail  <= fail_n;
      pass  <= pass_n;
      busy  <= busy_n;
      done  <= done_n;
    end
  end

  // Gate pins decode only from registered state, so they never depend on dut_out.
  assign bus.dut_a     = (state == DRIVE) & vec_a;
  assign bus.dut_b     = (state == DRIVE) & vec_b;
  assign bus.vec_idx   = idx;
  assign bus.busy      = busy;
  assign bus.done      = done;
  assign bus.pass      = pass;
  assign bus.err_count = err;
  assign bus.fail_vec  = fail;

endmodule
